// File: rtl/flash_pkg.sv
// Shared definitions for the flash loader: control-register bit map, block
// geometry, bus access-size encodings and the loader state enum.
package flash_pkg;

   localparam int CTRL_DONE_BIT = 31;
   localparam int CTRL_RD_BIT   = 30;
   localparam int CTRL_WR_BIT   = 29;
   localparam int CTRL_BLK_MSB  = 25;

   localparam int BLOCK_WORDS = 128;
   localparam int IDX_W       = $clog2(BLOCK_WORDS);

   localparam logic [1:0] SEL_BYTE = 2'd0;
   localparam logic [1:0] SEL_HALF = 2'd1;
   localparam logic [1:0] SEL_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_POLL,
      ST_RDBUF,
      ST_WRMEM,
      ST_CLEAR,
      ST_FIN
   } loader_state_t;

   function automatic logic [31:0] ctrl_word(input logic done_bit, input logic rd_bit,
                                             input logic wr_bit, input logic [25:0] blk);
      logic [31:0] w;
      w                   = '0;
      w[CTRL_DONE_BIT]    = done_bit;
      w[CTRL_RD_BIT]      = rd_bit;
      w[CTRL_WR_BIT]      = wr_bit;
      w[CTRL_BLK_MSB:0]   = blk;
      return w;
   endfunction

endpackage

// File: rtl/flash_loader.sv
// Bus-master DMA that copies consecutive 512-byte flash blocks into system memory.
// Optional running word sum on `checksum` when FLASH_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | write read request for current block to the control register
// POLL  | read control register until the done bit is set
// RDBUF | read buffer word idx
// WRMEM | write captured word to destination
// CLEAR | write zero to the control register, leaving the controller idle
// FIN   | one-cycle completion, done pulses on the following cycle
module flash_loader
   import flash_pkg::*;
#(
   parameter logic [31:0] FLASH_CTRL_ADDR = 32'hFFFF_FE00,
   parameter logic [31:0] FLASH_BUF_ADDR  = 32'hFFFF_FC00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [25:0] start_block,
   input  logic [15:0] block_count,
   input  logic [31:0] dest_addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] checksum,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   output logic [1:0]  sel_o,
   output logic        rd_o,
   output logic        we_o,
   input  logic        ack_i
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_WORDS - 1);

   loader_state_t state, state_nxt;

   logic [25:0]      blk, blk_n;
   logic [15:0]      rem, rem_n;
   logic [31:0]      dst, dst_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [31:0]      rdata, rdata_n;
   logic [31:0]      addr_n, data_n;
   logic             rd_n, we_n, busy_n, done_n;
   logic             accept;

   // A start coinciding with the done pulse is dropped so back-to-back runs need a fresh request.
   assign accept = (state == ST_IDLE) && start && !done;
   assign sel_o  = SEL_WORD;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = (block_count == 16'd0) ? ST_FIN : ST_ISSUE;
         ST_ISSUE: if (ack_i) state_nxt = ST_POLL;
         ST_POLL:  if (ack_i && data_i[CTRL_DONE_BIT]) state_nxt = ST_RDBUF;
         ST_RDBUF: if (ack_i) state_nxt = ST_WRMEM;
         ST_WRMEM: begin
            if (ack_i) begin
               if (idx == IDX_LAST) state_nxt = (rem == 16'd1) ? ST_CLEAR : ST_ISSUE;
               else                 state_nxt = ST_RDBUF;
            end
         end
         ST_CLEAR: if (ack_i) state_nxt = ST_FIN;
         ST_FIN:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each strobe is live in the
   // same cycle its state is, giving one cycle per transfer on a zero-wait bus.
   always_comb begin
      blk_n   = blk;
      rem_n   = rem;
      dst_n   = dst;
      idx_n   = idx;
      rdata_n = rdata;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               blk_n = start_block;
               rem_n = block_count;
               dst_n = dest_addr;
               idx_n = '0;
            end
         end
         ST_POLL:  if (ack_i && data_i[CTRL_DONE_BIT]) idx_n = '0;
         ST_RDBUF: if (ack_i) rdata_n = data_i;
         ST_WRMEM: begin
            if (ack_i) begin
               dst_n = dst + 32'd4;
               idx_n = idx + 1'b1;
               if (idx == IDX_LAST) begin
                  rem_n = rem - 16'd1;
                  blk_n = blk + 26'd1;
               end
            end
         end
         default: ;
      endcase

      addr_n = '0;
      data_n = '0;
      rd_n   = 1'b0;
      we_n   = 1'b0;
      case (state_nxt)
         ST_ISSUE: begin
            addr_n = FLASH_CTRL_ADDR;
            data_n = ctrl_word(1'b0, 1'b1, 1'b0, blk_n);
            we_n   = 1'b1;
         end
         ST_POLL: begin
            addr_n = FLASH_CTRL_ADDR;
            rd_n   = 1'b1;
         end
         ST_RDBUF: begin
            addr_n = FLASH_BUF_ADDR + {{(30 - IDX_W){1'b0}}, idx_n, 2'b00};
            rd_n   = 1'b1;
         end
         ST_WRMEM: begin
            addr_n = dst_n;
            data_n = rdata_n;
            we_n   = 1'b1;
         end
         ST_CLEAR: begin
            addr_n = FLASH_CTRL_ADDR;
            we_n   = 1'b1;
         end
         default: ;
      endcase
      busy_n = (state_nxt != ST_IDLE);
      done_n = (state == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk    <= '0;
         rem    <= '0;
         dst    <= '0;
         idx    <= '0;
         rdata  <= '0;
         addr_o <= '0;
         data_o <= '0;
         rd_o   <= 1'b0;
         we_o   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         blk    <= blk_n;
         rem    <= rem_n;
         dst    <= dst_n;
         idx    <= idx_n;
         rdata  <= rdata_n;
         addr_o <= addr_n;
         data_o <= data_n;
         rd_o   <= rd_n;
         we_o   <= we_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

`ifdef FLASH_LOADER_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst)                           sum_q <= '0;
      else if (accept)                   sum_q <= '0;
      else if (state == ST_RDBUF && ack_i) sum_q <= sum_q + data_i;
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: bus responder with flash controller model, write
// scoreboard and bus-stability monitor. Honours FLASH_LOADER_CHECKSUM_EN.
module tb_flash_loader;

   localparam logic [31:0] CTRL = 32'hFFFF_FE00;
   localparam logic [31:0] BUFA = 32'hFFFF_FC00;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [25:0] start_block = '0;
   logic [15:0] block_count = '0;
   logic [31:0] dest_addr = '0;
   logic        busy, done;
   logic [31:0] checksum, addr_o, data_o;
   logic [31:0] data_i;
   logic [1:0]  sel_o;
   logic        rd_o, we_o, ack_i;

   int checks = 0;
   int failures = 0;

   wr_t          exp_q[$];
   logic [31:0]  sysmem[logic [31:0]];
   logic [31:0]  exp_sum;

   int max_wait = 0;
   int poll_delay = 0;
   int wait_cnt = 0;
   logic        fdone = 1'b0;
   logic [25:0] fblk = '0;
   int          fbusy = 0;

   int done_cnt = 0, poll_cnt = 0, strobe_cyc = 0, wr_cnt = 0;
   logic [31:0] first_wr_data = '0, last_wr_addr = '0, last_wr_data = '0;
   logic        prev_wait = 1'b0, pw_rd = 1'b0, pw_we = 1'b0;
   logic [31:0] pw_addr = '0, pw_data = '0;

   flash_loader #(.FLASH_CTRL_ADDR(CTRL), .FLASH_BUF_ADDR(BUFA)) dut (
      .clk(clk), .rst(rst), .start(start), .start_block(start_block),
      .block_count(block_count), .dest_addr(dest_addr), .busy(busy), .done(done),
      .checksum(checksum), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
      .sel_o(sel_o), .rd_o(rd_o), .we_o(we_o), .ack_i(ack_i)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] buf_word(input logic [25:0] b, input int k);
      return {b[15:0], 16'(k + 1)};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (sysmem.exists(a)) return sysmem[a];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] exp_ck(input logic [31:0] s);
`ifdef FLASH_LOADER_CHECKSUM_EN
      return s;
`else
      return (s & 32'h0);
`endif
   endfunction

   assign ack_i = (rd_o | we_o) && (wait_cnt == 0);

   always_comb begin
      data_i = '0;
      if (rd_o) begin
         if (addr_o == CTRL)
            data_i = {fdone, 5'b0, fblk};
         else if (addr_o >= BUFA && addr_o < CTRL)
            data_i = buf_word(fblk, int'((addr_o - BUFA) >> 2));
         else
            data_i = 32'hDEAD_BEEF;
      end
   end

   // Flash controller model and ack delay generator
   always @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 0;
      end else if ((rd_o | we_o) && ack_i) begin
         wait_cnt <= int'($urandom_range(max_wait, 0));
         if (addr_o == CTRL) begin
            if (we_o) begin
               fdone <= 1'b0;
               if (data_o[30]) begin
                  fblk  <= data_o[25:0];
                  fbusy <= poll_delay;
               end
            end else if (!fdone) begin
               if (fbusy == 0) fdone <= 1'b1;
               else            fbusy <= fbusy - 1;
            end
         end
      end else if ((rd_o | we_o) && wait_cnt != 0) begin
         wait_cnt <= wait_cnt - 1;
      end
   end

   // Monitor: write scoreboard, bus stability, strobe exclusivity
   always @(negedge clk) begin
      wr_t e;
      if (rst) begin
         prev_wait = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (rd_o | we_o) strobe_cyc++;
         if (prev_wait) begin
            checks++;
            if (addr_o !== pw_addr || data_o !== pw_data || rd_o !== pw_rd || we_o !== pw_we) begin
               failures++;
               $display("FAIL bus_stable: got addr=%h data=%h rd=%b we=%b, held addr=%h data=%h rd=%b we=%b",
                        addr_o, data_o, rd_o, we_o, pw_addr, pw_data, pw_rd, pw_we);
            end
         end
         if ((rd_o | we_o) && ack_i) begin
            checks++;
            if ((rd_o && we_o) || sel_o !== 2'd2) begin
               failures++;
               $display("FAIL strobe_excl: rd=%b we=%b sel=%0d, need one strobe and sel=2", rd_o, we_o, sel_o);
            end
            if (rd_o && addr_o == CTRL) poll_cnt++;
            if (we_o) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_write: addr=%h data=%h, no write expected", addr_o, data_o);
               end else begin
                  e = exp_q.pop_front();
                  if (addr_o !== e.addr || data_o !== e.data) begin
                     failures++;
                     $display("FAIL write_sb: got addr=%h data=%h, expected addr=%h data=%h",
                              addr_o, data_o, e.addr, e.data);
                  end
               end
               if (addr_o != CTRL) sysmem[addr_o] = data_o;
               if (wr_cnt == 0) first_wr_data = data_o;
               last_wr_addr = addr_o;
               last_wr_data = data_o;
               wr_cnt++;
            end
         end
         prev_wait = (rd_o | we_o) && !ack_i;
         pw_addr = addr_o;
         pw_data = data_o;
         pw_rd   = rd_o;
         pw_we   = we_o;
      end
   end

   task automatic clear_counters();
      done_cnt = 0; poll_cnt = 0; strobe_cyc = 0; wr_cnt = 0;
   endtask

   task automatic push_run(input logic [25:0] sb, input int nb, input logic [31:0] dst);
      logic [31:0] a;
      logic [25:0] b;
      a = dst;
      b = sb;
      exp_sum = '0;
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(wr_t'{CTRL, 32'h4000_0000 | {6'b0, b}});
         for (int k = 0; k < 128; k++) begin
            exp_q.push_back(wr_t'{a, buf_word(b, k)});
            exp_sum = exp_sum + buf_word(b, k);
            a = a + 32'd4;
         end
         b = b + 26'd1;
      end
      if (nb > 0) exp_q.push_back(wr_t'{CTRL, 32'h0});
   endtask

   task automatic pulse_start(input logic [25:0] sb, input logic [15:0] nb, input logic [31:0] dst);
      @(negedge clk);
      start_block = sb;
      block_count = nb;
      dest_addr   = dst;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int n;
      for (n = 0; n < limit; n++) begin
         if (done) break;
         @(negedge clk);
      end
      checks++;
      if (n >= limit) begin
         failures++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, limit);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_end(input string name, input logic [31:0] ck_exp);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_sb_left: %0d writes outstanding, need 0", name, exp_q.size());
      end
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL %s_done_cnt: got %0d pulses, need 1", name, done_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy_idle: got %b, need 0", name, busy);
      end
      checks++;
      if (checksum !== ck_exp) begin
         failures++;
         $display("FAIL %s_checksum: got %h, need %h", name, checksum, ck_exp);
      end
      exp_q.delete();
   endtask

   task automatic check_outputs_reset(input string name);
      checks++;
      if (addr_o !== 32'h0 || data_o !== 32'h0 || rd_o !== 1'b0 || we_o !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || checksum !== 32'h0 || sel_o !== 2'd2) begin
         failures++;
         $display("FAIL %s: addr=%h data=%h rd=%b we=%b busy=%b done=%b ck=%h sel=%0d, need all zero with sel=2",
                  name, addr_o, data_o, rd_o, we_o, busy, done, checksum, sel_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_reset("reset_values");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_block();
      max_wait = 0;
      poll_delay = 3;
      clear_counters();
      push_run(26'd5, 1, 32'h1000);
      pulse_start(26'd5, 16'd1, 32'h1000);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL single_busy_rise: got %b, need 1", busy);
      end
      wait_done("single", 2000);
      checks++;
      if (first_wr_data !== 32'h4000_0005) begin
         failures++;
         $display("FAIL single_ctrl_cmd: got %h, need 40000005", first_wr_data);
      end
      checks++;
      if (last_wr_addr !== CTRL || last_wr_data !== 32'h0) begin
         failures++;
         $display("FAIL single_clear: got addr=%h data=%h, need addr=%h data=0", last_wr_addr, last_wr_data, CTRL);
      end
      checks++;
      if (poll_cnt != poll_delay + 2) begin
         failures++;
         $display("FAIL single_polls: got %0d, need %0d", poll_cnt, poll_delay + 2);
      end
      checks++;
      if (mem_rd(32'h1000) !== buf_word(5, 0) || mem_rd(32'h11FC) !== buf_word(5, 127)) begin
         failures++;
         $display("FAIL single_mem: got %h/%h, need %h/%h", mem_rd(32'h1000), mem_rd(32'h11FC),
                  buf_word(5, 0), buf_word(5, 127));
      end
      check_end("single", exp_ck(exp_sum));
   endtask

   task automatic test_zero_blocks();
      clear_counters();
      @(negedge clk);
      block_count = 16'd0;
      start_block = 26'd3;
      dest_addr   = 32'h5000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL zero_c1: got busy=%b done=%b, need 1/0", busy, done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_c2: got done=%b busy=%b, need 1/0", done, busy);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL start_on_done: got busy=%b done=%b, need 0/0", busy, done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (strobe_cyc != 0 || done_cnt != 1) begin
         failures++;
         $display("FAIL zero_traffic: got strobe cycles=%0d done pulses=%0d, need 0 and 1", strobe_cyc, done_cnt);
      end
   endtask

   task automatic test_random_wait();
      max_wait = 5;
      poll_delay = 2;
      clear_counters();
      push_run(26'd5, 3, 32'h4000);
      pulse_start(26'd5, 16'd3, 32'h4000);
      repeat (20) @(negedge clk);
      pulse_start(26'd40, 16'd7, 32'h9000);
      wait_done("randwait", 20000);
      for (int b = 0; b < 3; b++) begin
         checks++;
         if (mem_rd(32'h4000 + 32'(512 * b)) !== buf_word(26'(5 + b), 0) ||
             mem_rd(32'h41FC + 32'(512 * b)) !== buf_word(26'(5 + b), 127)) begin
            failures++;
            $display("FAIL randwait_mem_blk%0d: got %h/%h, need %h/%h", b,
                     mem_rd(32'h4000 + 32'(512 * b)), mem_rd(32'h41FC + 32'(512 * b)),
                     buf_word(26'(5 + b), 0), buf_word(26'(5 + b), 127));
         end
      end
      check_end("randwait", exp_ck(exp_sum));
   endtask

   task automatic test_reset_midop();
      int n;
      max_wait = 1;
      poll_delay = 1;
      clear_counters();
      push_run(26'h10, 3, 32'h8000);
      pulse_start(26'h10, 16'd3, 32'h8000);
      for (n = 0; n < 10000; n++) begin
         @(negedge clk);
         if (wr_cnt >= 265 && we_o && addr_o != CTRL) break;
      end
      checks++;
      if (n >= 10000) begin
         failures++;
         $display("FAIL midop_reach: block 2 copy not reached, writes=%0d", wr_cnt);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_reset("midop_reset_values");
      rst = 1'b0;
      exp_q.delete();
      clear_counters();
      push_run(26'd9, 1, 32'h2000);
      pulse_start(26'd9, 16'd1, 32'h2000);
      wait_done("after_reset", 5000);
      checks++;
      if (mem_rd(32'h2000) !== buf_word(9, 0) || mem_rd(32'h21FC) !== buf_word(9, 127)) begin
         failures++;
         $display("FAIL after_reset_mem: got %h/%h, need %h/%h", mem_rd(32'h2000), mem_rd(32'h21FC),
                  buf_word(9, 0), buf_word(9, 127));
      end
      check_end("after_reset", exp_ck(exp_sum));
   endtask

   task automatic test_checksum();
      logic [31:0] ck_need;
`ifdef FLASH_LOADER_CHECKSUM_EN
      ck_need = 32'h2040;
`else
      ck_need = 32'h0;
`endif
      max_wait = 0;
      poll_delay = 0;
      clear_counters();
      push_run(26'd0, 1, 32'h3000);
      pulse_start(26'd0, 16'd1, 32'h3000);
      wait_done("checksum", 2000);
      check_end("checksum", ck_need);
      repeat (10) @(negedge clk);
      checks++;
      if (checksum !== ck_need) begin
         failures++;
         $display("FAIL checksum_hold: got %h, need %h", checksum, ck_need);
      end
   endtask

   task automatic test_addr_wrap();
      max_wait = 2;
      poll_delay = 1;
      clear_counters();
      push_run(26'd1, 1, 32'hFFFF_FF00);
      pulse_start(26'd1, 16'd1, 32'hFFFF_FF00);
      wait_done("wrap", 5000);
      checks++;
      if (mem_rd(32'h0) !== buf_word(1, 64) || mem_rd(32'hFFFF_FFFC) !== buf_word(1, 63) ||
          mem_rd(32'h0000_00FC) !== buf_word(1, 127)) begin
         failures++;
         $display("FAIL wrap_mem: got %h/%h/%h, need %h/%h/%h", mem_rd(32'h0), mem_rd(32'hFFFF_FFFC),
                  mem_rd(32'h0000_00FC), buf_word(1, 64), buf_word(1, 63), buf_word(1, 127));
      end
      check_end("wrap", exp_ck(exp_sum));
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_zero_blocks();
      test_random_wait();
      test_reset_midop();
      test_checksum();
      test_addr_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
